// File: rtl/branch_resolve.sv
// Single-stage branch resolver: condition decode, target/fall-through select, mispredict flag.
// Optional BRANCH_STATS_EN adds resolved/mispredict handshake counters with synchronous clear.
module branch_resolve (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] pc,
    input  logic [63:0] offset,
    input  logic [2:0]  cond,
    input  logic        zero,
    input  logic        negitive,
    input  logic        pred_taken,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        taken,
    output logic        mispredict,
    output logic [63:0] next_pc
`ifdef BRANCH_STATS_EN
    ,
    input  logic        stats_clear,
    output logic [31:0] resolved_count,
    output logic [31:0] mispredict_count
`endif
);

    typedef enum logic [2:0] {
        COND_EQ     = 3'b000,
        COND_NE     = 3'b001,
        COND_LT     = 3'b010,
        COND_GE     = 3'b011,
        COND_LE     = 3'b100,
        COND_GT     = 3'b101,
        COND_ALWAYS = 3'b110,
        COND_NEVER  = 3'b111
    } cond_e;

    logic        valid_q, valid_d;
    logic        taken_q, taken_d;
    logic        mispred_q, mispred_d;
    logic [63:0] npc_q, npc_d;
    logic        accept;
    logic        out_hs;
    logic        cond_met;

    assign in_ready = (!valid_q || out_ready) && !flush;
    assign accept   = in_valid && in_ready;
    // A handshake coinciding with flush is killed along with the result.
    assign out_hs   = valid_q && out_ready && !flush;

    always_comb begin
        cond_met = 1'b0;
        case (cond_e'(cond))
            COND_EQ:     cond_met = zero;
            COND_NE:     cond_met = !zero;
            COND_LT:     cond_met = negitive;
            COND_GE:     cond_met = !negitive;
            COND_LE:     cond_met = zero || negitive;
            COND_GT:     cond_met = !zero && !negitive;
            COND_ALWAYS: cond_met = 1'b1;
            COND_NEVER:  cond_met = 1'b0;
            default:     cond_met = 1'b0;
        endcase
    end

    always_comb begin
        valid_d   = valid_q;
        taken_d   = taken_q;
        mispred_d = mispred_q;
        npc_d     = npc_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d   = 1'b1;
            taken_d   = cond_met;
            mispred_d = cond_met ^ pred_taken;
            npc_d     = cond_met ? (pc + offset) : (pc + 64'd4);
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q   <= 1'b0;
            taken_q   <= 1'b0;
            mispred_q <= 1'b0;
            npc_q     <= '0;
        end else begin
            valid_q   <= valid_d;
            taken_q   <= taken_d;
            mispred_q <= mispred_d;
            npc_q     <= npc_d;
        end
    end

    assign out_valid  = valid_q;
    assign taken      = taken_q;
    assign mispredict = mispred_q;
    assign next_pc    = npc_q;

`ifdef BRANCH_STATS_EN
    logic [31:0] res_cnt_q, res_cnt_d;
    logic [31:0] mis_cnt_q, mis_cnt_d;

    always_comb begin
        res_cnt_d = res_cnt_q;
        mis_cnt_d = mis_cnt_q;
        if (stats_clear) begin
            res_cnt_d = '0;
            mis_cnt_d = '0;
        end else if (out_hs) begin
            res_cnt_d = res_cnt_q + 32'd1;
            mis_cnt_d = mis_cnt_q + {31'd0, mispred_q};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            res_cnt_q <= '0;
            mis_cnt_q <= '0;
        end else begin
            res_cnt_q <= res_cnt_d;
            mis_cnt_q <= mis_cnt_d;
        end
    end

    assign resolved_count   = res_cnt_q;
    assign mispredict_count = mis_cnt_q;
`else
    logic unused_hs;
    assign unused_hs = out_hs;
`endif

endmodule
